// File: rtl/vrf_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vrf_sched_pkg
// Description : Shared types, constants and helpers for the VRF bank scheduler.
//               Provides the SEW and FSM state encodings, the vreg-to-bank/row
//               split and the beats-per-op calculation.
// Revision    : 1.0 - initial release
// ============================================================================
package vrf_sched_pkg;

  localparam int unsigned VLEN_DEF       = 256;
  localparam int unsigned NUM_LANES_DEF  = 4;
  localparam int unsigned WORDS_PER_VREG = 16;
  localparam int unsigned BANK_W         = 2;  // vreg[4:3]
  localparam int unsigned ROW_W          = 3;  // vreg[2:0]
  localparam int unsigned BEAT_W         = 4;  // beat index / count (max 8)

  typedef enum logic [1:0] {
    SEW8  = 2'd0,
    SEW16 = 2'd1,
    SEW32 = 2'd2,
    SEW64 = 2'd3
  } sew_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RD_A  = 2'd1,
    S_RD_B  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  // Element-group beats for one op: VLEN / (lanes * SEW).
  function automatic logic [BEAT_W-1:0] beats(input sew_e sew,
                                              input int unsigned vlen  = VLEN_DEF,
                                              input int unsigned lanes = NUM_LANES_DEF);
    int unsigned n8;
    n8 = vlen / (lanes * 8);
    return BEAT_W'(n8 >> int'(sew));
  endfunction

  function automatic logic [BANK_W-1:0] bank_of(input logic [4:0] vreg);
    return vreg[4:3];
  endfunction

  function automatic logic [ROW_W-1:0] row_of(input logic [4:0] vreg);
    return vreg[2:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/vrf_bank_scheduler_wb_pipe.sv
`default_nettype none
// ============================================================================
// Module      : vrf_wb_pipe
// Description : Fixed-latency write-back delay line. Every cycle each entry
//               moves one stage; an entry pushed at edge t reaches the head
//               DEPTH-1 cycles later. Carries valid, target bank and address.
// Ports       : clk, rstn        - clock, async active-low reset
//               push_i           - enqueue an entry this cycle
//               push_bank_i/addr - entry payload
//               head_*_o         - last stage (write to perform next cycle)
//               empty_o          - no valid entry in any stage
// Revision    : 1.0 - initial release
// ============================================================================
module vrf_wb_pipe #(
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned BANK_W = 2,
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push_i,
  input  logic [BANK_W-1:0] push_bank_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  output logic              head_valid_o,
  output logic [BANK_W-1:0] head_bank_o,
  output logic [ADDR_W-1:0] head_addr_o,
  output logic              empty_o
);

  logic [DEPTH-1:0]  valid_q;
  logic [BANK_W-1:0] bank_q [DEPTH];
  logic [ADDR_W-1:0] addr_q [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        bank_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      // DEPTH >= 2 because ALU latency is at least one cycle.
      valid_q   <= {valid_q[DEPTH-2:0], push_i};
      bank_q[0] <= push_bank_i;
      addr_q[0] <= push_addr_i;
      for (int i = 1; i < DEPTH; i++) begin
        bank_q[i] <= bank_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  assign head_valid_o = valid_q[DEPTH-1];
  assign head_bank_o  = bank_q[DEPTH-1];
  assign head_addr_o  = addr_q[DEPTH-1];
  assign empty_o      = ~|valid_q;

endmodule
`default_nettype wire

// File: rtl/vrf_bank_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : vrf_bank_scheduler
// Description : Sequences one vector ALU op through four single-port VRF
//               banks and lockstep lane ALUs: reads vs1/vs2 per beat, raises
//               alu_en one cycle later and writes vd ALU_LAT cycles after
//               that. Pending writes take priority; conflicting reads stall.
// Macro       : VRF_BANK_CONFLICT_EN - serialise same-bank vs1/vs2 through
//               RD_A/RD_B with cap_a; when undefined such ops are rejected.
// Ports       : op_valid/op_ready + op_* / vsew  - op handshake and fields
//               bank_cs/oe/we/addr               - registered SRAM controls
//               sel_a/sel_b/sel_c/cap_a          - lane operand steering
//               alu_en/alu_sel/alu_width         - ALU controls
//               busy/done/err                    - status
// Revision    : 1.0 - initial release
// ============================================================================
module vrf_bank_scheduler
  import vrf_sched_pkg::*;
#(
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned ADDR_W    = 7,
  parameter int unsigned VLEN      = 256,
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned ALU_LAT   = 2
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          op_valid,
  output logic                          op_ready,
  input  logic [2:0]                    op_alu_sel,
  input  logic [4:0]                    op_vs1,
  input  logic [4:0]                    op_vs2,
  input  logic [4:0]                    op_vd,
  input  logic [2:0]                    vsew,
  output logic [NUM_BANKS-1:0]          bank_cs,
  output logic [NUM_BANKS-1:0]          bank_oe,
  output logic [NUM_BANKS-1:0]          bank_we,
  output logic [NUM_BANKS*ADDR_W-1:0]   bank_addr,
  output logic [1:0]                    sel_a,
  output logic [1:0]                    sel_b,
  output logic [1:0]                    sel_c,
  output logic                          cap_a,
  output logic                          alu_en,
  output logic [2:0]                    alu_sel,
  output logic [1:0]                    alu_width,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

`ifdef VRF_BANK_CONFLICT_EN
  localparam bit CONF_EN = 1'b1;
`else
  localparam bit CONF_EN = 1'b0;
`endif

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ROW_W-1:0]  row,
                                                  input logic [BEAT_W-1:0] beat);
    return ADDR_W'(int'(row) * WORDS_PER_VREG + int'(beat));
  endfunction

  // ---------------- state and latched op ----------------
  state_e              state_q, state_d;
  logic [BANK_W-1:0]   b1_q, b2_q, bd_q;
  logic [ROW_W-1:0]    r1_q, r2_q, rd_q;
  logic                conf_q;
  logic [BEAT_W-1:0]   nbeats_q, beat_q, beat_d;
  logic [2:0]          alu_sel_q;
  logic [1:0]          width_q;

  // ---------------- registered outputs ----------------
  logic [NUM_BANKS-1:0]        cs_q, oe_q, we_q;
  logic [NUM_BANKS*ADDR_W-1:0] addr_q;
  logic [1:0]                  sel_a_q, sel_b_q;
  logic                        iss_q, alu_en_q, rej_q, err_q, done_q;

  // ---------------- combinational ----------------
  logic                        w_accept, w_reject, w_start, w_conflict;
  logic [NUM_BANKS-1:0]        w_rd_mask;
  logic                        w_stall, w_rd_go, w_issue, w_last;
  logic [NUM_BANKS-1:0]        cs_d, oe_d, we_d;
  logic [NUM_BANKS*ADDR_W-1:0] addr_d;
  logic                        w_head_valid, w_pipe_empty;
  logic [BANK_W-1:0]           w_head_bank;
  logic [ADDR_W-1:0]           w_head_addr;

  assign w_accept   = op_valid && (state_q == S_IDLE);
  assign w_conflict = (bank_of(op_vs1) == bank_of(op_vs2)) && (op_vs1 != op_vs2);
  assign w_reject   = vsew[2] || (w_conflict && !CONF_EN);
  assign w_start    = w_accept && !w_reject;

  // Banks the current read wants; a write due next cycle on any of them wins.
  always_comb begin
    w_rd_mask = '0;
    case (state_q)
      S_RD_A: begin
        w_rd_mask[b1_q] = 1'b1;
        if (!conf_q) w_rd_mask[b2_q] = 1'b1;
      end
      S_RD_B:  w_rd_mask[b2_q] = 1'b1;
      default: w_rd_mask = '0;
    endcase
  end

  assign w_stall = w_head_valid && w_rd_mask[w_head_bank];
  assign w_rd_go = (|w_rd_mask) && !w_stall;
  // A serialised op only issues on its second (vs2) read.
  assign w_issue = w_rd_go && ((state_q == S_RD_B) || !conf_q);
  assign w_last  = (beat_q == nbeats_q - BEAT_W'(1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (w_start) state_d = S_RD_A;
      S_RD_A: begin
        if (w_issue && w_last) state_d = S_DRAIN;
`ifdef VRF_BANK_CONFLICT_EN
        else if (w_rd_go && !w_issue) state_d = S_RD_B;
`endif
      end
`ifdef VRF_BANK_CONFLICT_EN
      S_RD_B: if (w_rd_go) state_d = w_last ? S_DRAIN : S_RD_A;
`endif
      // done is raised while still in DRAIN so op_ready stays low that cycle.
      S_DRAIN: if (done_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs (bank controls) ----------------
  always_comb begin
    cs_d   = '0;
    oe_d   = '0;
    we_d   = '0;
    addr_d = '0;
    if (w_rd_go) begin
      if (state_q == S_RD_B) begin
        cs_d[b2_q] = 1'b1;
        oe_d[b2_q] = 1'b1;
        addr_d[int'(b2_q)*ADDR_W +: ADDR_W] = word_addr(r2_q, beat_q);
      end else begin
        cs_d[b1_q] = 1'b1;
        oe_d[b1_q] = 1'b1;
        addr_d[int'(b1_q)*ADDR_W +: ADDR_W] = word_addr(r1_q, beat_q);
        // vs1 == vs2 lands on the same bank/address: one read serves both.
        if (!conf_q) begin
          cs_d[b2_q] = 1'b1;
          oe_d[b2_q] = 1'b1;
          addr_d[int'(b2_q)*ADDR_W +: ADDR_W] = word_addr(r2_q, beat_q);
        end
      end
    end
    if (w_head_valid) begin
      cs_d[w_head_bank] = 1'b1;
      we_d[w_head_bank] = 1'b1;
      addr_d[int'(w_head_bank)*ADDR_W +: ADDR_W] = w_head_addr;
    end
  end

  always_comb begin
    beat_d = beat_q;
    if (w_start)      beat_d = '0;
    else if (w_issue) beat_d = beat_q + BEAT_W'(1);
  end

  // ---------------- op latch and output registers ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      b1_q      <= '0;
      b2_q      <= '0;
      bd_q      <= '0;
      r1_q      <= '0;
      r2_q      <= '0;
      rd_q      <= '0;
      conf_q    <= 1'b0;
      nbeats_q  <= '0;
      beat_q    <= '0;
      alu_sel_q <= '0;
      width_q   <= '0;
      cs_q      <= '0;
      oe_q      <= '0;
      we_q      <= '0;
      addr_q    <= '0;
      sel_a_q   <= '0;
      sel_b_q   <= '0;
      iss_q     <= 1'b0;
      alu_en_q  <= 1'b0;
      rej_q     <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (w_start) begin
        b1_q      <= bank_of(op_vs1);
        b2_q      <= bank_of(op_vs2);
        bd_q      <= bank_of(op_vd);
        r1_q      <= row_of(op_vs1);
        r2_q      <= row_of(op_vs2);
        rd_q      <= row_of(op_vd);
        conf_q    <= w_conflict;
        nbeats_q  <= beats(sew_e'(vsew[1:0]), VLEN, NUM_LANES);
        alu_sel_q <= op_alu_sel;
        width_q   <= vsew[1:0];
      end
      beat_q   <= beat_d;
      cs_q     <= cs_d;
      oe_q     <= oe_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      iss_q    <= w_issue;
      // Read data is on the bank outputs one cycle after the read.
      alu_en_q <= iss_q;
      sel_a_q  <= iss_q ? b1_q : '0;
      sel_b_q  <= iss_q ? b2_q : '0;
      rej_q    <= w_accept && w_reject;
      err_q    <= rej_q;
      done_q   <= (state_q == S_DRAIN) && w_pipe_empty && !done_q;
    end
  end

`ifdef VRF_BANK_CONFLICT_EN
  logic w_cap_rd, cap_rd_q, cap_a_q;
  assign w_cap_rd = w_rd_go && (state_q == S_RD_A) && conf_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cap_rd_q <= 1'b0;
      cap_a_q  <= 1'b0;
    end else begin
      cap_rd_q <= w_cap_rd;
      cap_a_q  <= cap_rd_q;  // strobe when the vs1 word is on the bank output
    end
  end
  assign cap_a = cap_a_q;
`else
  assign cap_a = 1'b0;
`endif

  vrf_wb_pipe #(
    .DEPTH  (ALU_LAT + 1),
    .BANK_W (BANK_W),
    .ADDR_W (ADDR_W)
  ) u_wb_pipe (
    .clk          (clk),
    .rstn         (rstn),
    .push_i       (w_issue),
    .push_bank_i  (bd_q),
    .push_addr_i  (word_addr(rd_q, beat_q)),
    .head_valid_o (w_head_valid),
    .head_bank_o  (w_head_bank),
    .head_addr_o  (w_head_addr),
    .empty_o      (w_pipe_empty)
  );

  assign op_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign bank_cs   = cs_q;
  assign bank_oe   = oe_q;
  assign bank_we   = we_q;
  assign bank_addr = addr_q;
  assign sel_a     = sel_a_q;
  assign sel_b     = sel_b_q;
  assign sel_c     = 2'd0;
  assign alu_en    = alu_en_q;
  assign alu_sel   = alu_sel_q;
  assign alu_width = width_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_vrf_bank_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_vrf_bank_scheduler
// Description : Directed self-checking bench for vrf_bank_scheduler. Each op
//               is accepted at edge 0; outputs are snapshotted 1 time unit
//               after every following edge (cycle c) and compared against
//               hand-derived values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vrf_bank_scheduler;

  localparam int NC = 24;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [2:0]  op_alu_sel = '0;
  logic [4:0]  op_vs1 = '0, op_vs2 = '0, op_vd = '0;
  logic [2:0]  vsew = '0;
  logic [3:0]  bank_cs, bank_oe, bank_we;
  logic [27:0] bank_addr;
  logic [1:0]  sel_a, sel_b, sel_c;
  logic        cap_a, alu_en;
  logic [2:0]  alu_sel;
  logic [1:0]  alu_width;
  logic        busy, done, err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0]  s_cs [NC];
  logic [3:0]  s_oe [NC];
  logic [3:0]  s_we [NC];
  logic [27:0] s_addr [NC];
  logic        s_cap [NC];
  logic        s_en [NC];
  logic        s_done [NC];
  logic        s_err [NC];
  logic        s_rdy [NC];
  logic [1:0]  s_sa [NC];
  logic [1:0]  s_sb [NC];

  vrf_bank_scheduler dut (
    .clk        (clk),
    .rstn       (rstn),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_alu_sel (op_alu_sel),
    .op_vs1     (op_vs1),
    .op_vs2     (op_vs2),
    .op_vd      (op_vd),
    .vsew       (vsew),
    .bank_cs    (bank_cs),
    .bank_oe    (bank_oe),
    .bank_we    (bank_we),
    .bank_addr  (bank_addr),
    .sel_a      (sel_a),
    .sel_b      (sel_b),
    .sel_c      (sel_c),
    .cap_a      (cap_a),
    .alu_en     (alu_en),
    .alu_sel    (alu_sel),
    .alu_width  (alu_width),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] addr_of(input int c, input int b);
    logic [27:0] w;
    w = s_addr[c];
    return w[b*7 +: 7];
  endfunction

  task automatic snap(input int c);
    s_cs[c]   = bank_cs;
    s_oe[c]   = bank_oe;
    s_we[c]   = bank_we;
    s_addr[c] = bank_addr;
    s_cap[c]  = cap_a;
    s_en[c]   = alu_en;
    s_done[c] = done;
    s_err[c]  = err;
    s_rdy[c]  = op_ready;
    s_sa[c]   = sel_a;
    s_sb[c]   = sel_b;
  endtask

  // Offer one op for a single cycle (accepted at edge 0) and record NC cycles.
  task automatic run_op(input logic [4:0] vs1, input logic [4:0] vs2, input logic [4:0] vd,
                        input logic [2:0] sew, input logic [2:0] asel);
    @(negedge clk);
    op_valid   = 1'b1;
    op_vs1     = vs1;
    op_vs2     = vs2;
    op_vd      = vd;
    vsew       = sew;
    op_alu_sel = asel;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    vsew     = 3'd0;
    snap(0);
    for (int c = 1; c < NC; c++) begin
      @(posedge clk);
      #1;
      snap(c);
    end
  endtask

  initial begin
    int cnt;
    int wc[8];
    int rc[8];

    // ---------------- reset ----------------
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", op_ready, 1);
    chk("rst_busy",  busy, 0);
    chk("rst_cs",    bank_cs, 0);
    chk("rst_done",  done, 0);
    chk("rst_err",   err, 0);
    chk("rst_alu_en", alu_en, 0);
    @(negedge clk);
    rstn = 1'b1;

    // ---------------- T1: SEW32, vs1=1 vs2=9 vd=17 ----------------
    run_op(5'd1, 5'd9, 5'd17, 3'd2, 3'd5);
    chk("t1_cs1", s_cs[1], 4'b0011);
    chk("t1_oe1", s_oe[1], 4'b0011);
    chk("t1_we1", s_we[1], 4'b0000);
    chk("t1_a1b0", addr_of(1, 0), 16);
    chk("t1_a1b1", addr_of(1, 1), 16);
    chk("t1_cs2", s_cs[2], 4'b0011);
    chk("t1_a2b0", addr_of(2, 0), 17);
    chk("t1_a2b1", addr_of(2, 1), 17);
    chk("t1_cs3", s_cs[3], 4'b0000);
    chk("t1_en1", s_en[1], 0);
    chk("t1_en2", s_en[2], 1);
    chk("t1_en3", s_en[3], 1);
    chk("t1_en4", s_en[4], 0);
    chk("t1_sa2", s_sa[2], 0);
    chk("t1_sb2", s_sb[2], 1);
    chk("t1_cs4", s_cs[4], 4'b0100);
    chk("t1_we4", s_we[4], 4'b0100);
    chk("t1_oe4", s_oe[4], 4'b0000);
    chk("t1_a4b2", addr_of(4, 2), 16);
    chk("t1_we5", s_we[5], 4'b0100);
    chk("t1_a5b2", addr_of(5, 2), 17);
    chk("t1_we6", s_we[6], 4'b0000);
    chk("t1_done5", s_done[5], 0);
    chk("t1_done6", s_done[6], 1);
    chk("t1_done7", s_done[7], 0);
    chk("t1_rdy0", s_rdy[0], 0);
    chk("t1_rdy6", s_rdy[6], 0);
    chk("t1_rdy7", s_rdy[7], 1);
    chk("t1_alu_sel", alu_sel, 5);
    chk("t1_alu_width", alu_width, 2);

    // ---------------- T2: SEW64, vs1=vs2=3, vd=11 ----------------
    run_op(5'd3, 5'd3, 5'd11, 3'd3, 3'd1);
    chk("t2_cs1", s_cs[1], 4'b0001);
    chk("t2_oe1", s_oe[1], 4'b0001);
    chk("t2_a1b0", addr_of(1, 0), 48);
    chk("t2_cs2", s_cs[2], 4'b0000);
    chk("t2_en2", s_en[2], 1);
    chk("t2_sa2", s_sa[2], 0);
    chk("t2_sb2", s_sb[2], 0);
    chk("t2_cs4", s_cs[4], 4'b0010);
    chk("t2_we4", s_we[4], 4'b0010);
    chk("t2_a4b1", addr_of(4, 1), 48);
    chk("t2_done4", s_done[4], 0);
    chk("t2_done5", s_done[5], 1);

    // ---------------- T3: same-bank vs1/vs2 (vs1=0, vs2=1, vd=24) ----------------
    run_op(5'd0, 5'd1, 5'd24, 3'd1, 3'd2);
`ifdef VRF_BANK_CONFLICT_EN
    for (int k = 0; k < 4; k++) begin
      chk("t3_cs_a",   s_cs[1+2*k], 4'b0001);
      chk("t3_addr_a", addr_of(1+2*k, 0), k);
      chk("t3_cs_b",   s_cs[2+2*k], 4'b0001);
      chk("t3_addr_b", addr_of(2+2*k, 0), 16 + k);
      chk("t3_cap",    s_cap[2+2*k], 1);
      chk("t3_en_off", s_en[2+2*k], 0);
      chk("t3_en_on",  s_en[3+2*k], 1);
      chk("t3_cap_off", s_cap[3+2*k], 0);
      chk("t3_we",     s_we[5+2*k], 4'b1000);
      chk("t3_waddr",  addr_of(5+2*k, 3), k);
    end
    chk("t3_done11", s_done[11], 0);
    chk("t3_done12", s_done[12], 1);
`else
    chk("t3_err0", s_err[0], 0);
    chk("t3_err1", s_err[1], 1);
    chk("t3_err2", s_err[2], 0);
    cnt = 0;
    for (int c = 0; c < NC; c++) if (s_cs[c] != 4'b0000 || !s_rdy[c] || s_cap[c]) cnt++;
    chk("t3_no_access", cnt, 0);
`endif

    // ---------------- T4: SEW8, write/read stalls on bank0 ----------------
    run_op(5'd0, 5'd8, 5'd2, 3'd0, 3'd0);
    cnt = 0;
    for (int c = 0; c < NC; c++) if (s_oe[c][0] && s_we[c][0]) cnt++;
    chk("t4_oe_we_overlap", cnt, 0);
    wc = '{4, 5, 6, 10, 11, 12, 16, 17};
    rc = '{1, 2, 3, 7, 8, 9, 13, 14};
    for (int k = 0; k < 8; k++) begin
      chk("t4_we_cycle", s_we[wc[k]], 4'b0001);
      chk("t4_we_addr",  addr_of(wc[k], 0), 32 + k);
      chk("t4_rd_cycle", s_oe[rc[k]], 4'b0011);
      chk("t4_rd_addr",  addr_of(rc[k], 1), k);
    end
    cnt = 0;
    for (int c = 0; c < NC; c++) if (s_we[c][0]) cnt++;
    chk("t4_write_count", cnt, 8);
    cnt = 0;
    for (int c = 0; c < NC; c++) if (s_done[c]) cnt++;
    chk("t4_done_count", cnt, 1);
    chk("t4_done18", s_done[18], 1);

    // ---------------- T5: illegal SEW ----------------
    run_op(5'd0, 5'd8, 5'd2, 3'd5, 3'd0);
    chk("t5_err1", s_err[1], 1);
    cnt = 0;
    for (int c = 0; c < NC; c++) if (s_err[c]) cnt++;
    chk("t5_err_count", cnt, 1);
    cnt = 0;
    for (int c = 0; c < NC; c++) if (s_cs[c] != 4'b0000 || !s_rdy[c]) cnt++;
    chk("t5_no_access", cnt, 0);

    // ---------------- T6: reset during a SEW8 op ----------------
    @(negedge clk);
    op_valid = 1'b1;
    op_vs1   = 5'd0;
    op_vs2   = 5'd8;
    op_vd    = 5'd2;
    vsew     = 3'd0;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_cs_before", bank_cs, 4'b0011);
    rstn = 1'b0;
    #1;
    chk("t6_cs",     bank_cs, 0);
    chk("t6_oe",     bank_oe, 0);
    chk("t6_we",     bank_we, 0);
    chk("t6_alu_en", alu_en, 0);
    chk("t6_ready",  op_ready, 1);
    chk("t6_busy",   busy, 0);
    @(negedge clk);
    rstn = 1'b1;
    run_op(5'd1, 5'd9, 5'd17, 3'd2, 3'd5);
    chk("t6_cs1",   s_cs[1], 4'b0011);
    chk("t6_we4",   s_we[4], 4'b0100);
    chk("t6_a5b2",  addr_of(5, 2), 17);
    chk("t6_done6", s_done[6], 1);
    cnt = 0;
    for (int c = 0; c < NC; c++) if (s_done[c]) cnt++;
    chk("t6_done_count", cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
